// File: rtl/img_processing_pkg.sv
// Shared types and defaults for the image-processing stream blocks.
package img_processing_pkg;

  // System-wide image geometry and stream data width defaults
  localparam int IMG_W            = 16;
  localparam int IMG_H            = 16;
  localparam int AXIS_TDATA_WIDTH = 8;

  // Frame streamer defaults derived from the system geometry
  localparam int STREAMER_PIXEL_WIDTH = AXIS_TDATA_WIDTH;
  localparam int STREAMER_MAX_W       = IMG_W;
  localparam int STREAMER_MAX_H       = IMG_H;

  // Frame streamer read-side sequencing states
  typedef enum logic [1:0] {
    IDLE,
    LINE,
    GAP,
    DRAIN
  } streamer_state_t;

  // A frame geometry is usable when it is non-empty, fits the buffer and
  // splits into whole beats
  function automatic logic streamer_cfg_ok(input int width, input int height,
                                           input int max_w, input int max_h,
                                           input int ppb);
    return (width != 0) && (height != 0) && (width <= max_w) &&
           (height <= max_h) && ((width % ppb) == 0);
  endfunction

endpackage

// File: rtl/axis_frame_streamer_out_buf.sv
// Two-entry valid/ready output buffer with registered outputs and an
// occupancy count used by the upstream read credit logic.
module axis_out_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         valid,
  input  logic         ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop;
  logic         push;

  assign pop     = valid & ready;
  assign push    = wr_en && ((count != 2'd2) || pop);
  assign valid   = (count != 2'd0);
  assign rd_data = mem[rd_ptr];

  // Circular storage: the head entry is never overwritten while it is
  // still being presented, so the output stays stable under stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_streamer.sv
// AXI-Stream frame source: walks a frame buffer in raster order and emits
// the beats with tuser on the first beat of a frame and tlast per line.
module axis_frame_streamer
  import img_processing_pkg::*;
#(
  parameter int PIXEL_WIDTH = STREAMER_PIXEL_WIDTH,
  parameter int CHANNELS    = 1,
  parameter int PPB         = 1,
  parameter int MAX_W       = STREAMER_MAX_W,
  parameter int MAX_H       = STREAMER_MAX_H,
  localparam int DW         = PPB * CHANNELS * PIXEL_WIDTH,
  localparam int BEAT_AW    = $clog2(MAX_W * MAX_H / PPB),
  localparam int WW         = $clog2(MAX_W + 1),
  localparam int HW         = $clog2(MAX_H + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WW-1:0]      cfg_width,
  input  logic [HW-1:0]      cfg_height,
  input  logic [7:0]         cfg_line_gap,
  input  logic               cfg_continuous,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err,
  output logic               rd_en,
  output logic [BEAT_AW-1:0] rd_addr,
  input  logic [DW-1:0]      rd_data,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser
);

  streamer_state_t state;

  logic [WW-1:0] bpl_r;
  logic [WW-1:0] beat_cnt;
  logic [HW-1:0] height_r;
  logic [HW-1:0] line_cnt;
  logic [7:0]    gap_r;
  logic [7:0]    gap_cnt;

  logic          in_flight;
  logic          fl_tuser;
  logic          fl_tlast;
  logic [1:0]    buf_count;
  logic [2:0]    credits_used;
  logic          pop;
  logic          last_beat;
  logic          last_line;
  logic          issue_tuser;
  logic          last_pop;
  logic          cfg_ok;

  assign pop          = m_axis_tvalid & m_axis_tready;
  assign credits_used = {1'b0, buf_count} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_en        = (state == LINE) && (credits_used < 3'd2);
  assign last_beat    = (beat_cnt == (bpl_r - WW'(1)));
  assign last_line    = (line_cnt == (height_r - HW'(1)));
  assign issue_tuser  = (beat_cnt == '0) && (line_cnt == '0);
  assign last_pop     = (state == DRAIN) && pop && (buf_count == 2'd1) && !in_flight;
  assign cfg_ok       = streamer_cfg_ok(int'(cfg_width), int'(cfg_height),
                                        MAX_W, MAX_H, PPB);

  // Track the one-cycle read latency and carry the beat's sideband with it
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= 1'b0;
      fl_tuser  <= 1'b0;
      fl_tlast  <= 1'b0;
    end else begin
      in_flight <= rd_en;
      fl_tuser  <= issue_tuser;
      fl_tlast  <= last_beat;
    end
  end

  // Frame sequencing: start validation, raster addressing, blanking, drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      rd_addr    <= '0;
      bpl_r      <= '0;
      beat_cnt   <= '0;
      height_r   <= '0;
      line_cnt   <= '0;
      gap_r      <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              bpl_r    <= WW'(int'(cfg_width) / PPB);
              height_r <= cfg_height;
              gap_r    <= cfg_line_gap;
              rd_addr  <= '0;
              beat_cnt <= '0;
              line_cnt <= '0;
              busy     <= 1'b1;
              state    <= LINE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LINE: begin
          if (rd_en) begin
            rd_addr <= rd_addr + BEAT_AW'(1);
            if (last_beat) begin
              beat_cnt <= '0;
              if (last_line) begin
                state <= DRAIN;
              end else begin
                line_cnt <= line_cnt + HW'(1);
                if (gap_r != 8'd0) begin
                  gap_cnt <= gap_r;
                  state   <= GAP;
                end
              end
            end else begin
              beat_cnt <= beat_cnt + WW'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd1) begin
            state <= LINE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            frame_done <= 1'b1;
            rd_addr    <= '0;
            beat_cnt   <= '0;
            line_cnt   <= '0;
            if (cfg_continuous) begin
              state <= LINE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_buf #(
    .W(DW + 2)
  ) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_flight),
    .wr_data ({fl_tuser, fl_tlast, rd_data}),
    .rd_data ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .valid   (m_axis_tvalid),
    .ready   (m_axis_tready),
    .count   (buf_count)
  );

endmodule

// File: doc/axis_frame_streamer.md
# axis_frame_streamer

Synthesisable AXI-Stream video frame source: reads a stored frame out of a frame-buffer read port and emits it as a raster stream. Each frame's first beat carries tuser (start of frame); each line's last beat carries tlast (end of line). Generalises our fixed 8-bit, 1-pixel, single-shot stimulus with:
- runtime frame size;
- multiple channels and pixels per beat;
- inter-line blanking;
- continuous mode;
- full backpressure support.

It sits in front of img_processor, both on hardware and in system benches.

## Interface
- PIXEL_WIDTH, 8, bits per channel
- CHANNELS, 1, channels per pixel
- PPB, 1, pixels per beat
- MAX_W, IMG_W, maximum line width in pixels
- MAX_H, IMG_H, maximum frame height in lines
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin streaming
- cfg_width  in  $clog2(MAX_W+1)  pixels per line; sampled on accepted start
- cfg_height  in  $clog2(MAX_H+1)  lines per frame; sampled on accepted start
- cfg_line_gap  in  8  idle read cycles between lines
- cfg_continuous  in  1  repeat frames; sampled at each frame end
- busy  out  1  high from accepted start until final frame_done
- frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  BEAT_AW  beat address; BEAT_AW = $clog2(MAX_W*MAX_H/PPB)
- rd_data  in  DW  read data, returned exactly 1 cycle after rd_en; DW = PPB*CHANNELS*PIXEL_WIDTH
- m_axis  master  axi_stream_if(TDATA_WIDTH_P=DW, TUSER_WIDTH_P=1)  output stream (tdata, tvalid, tready, tlast, tuser)

## Operation
- Pixel p of a beat occupies tdata[p*CHANNELS*PIXEL_WIDTH +: CHANNELS*PIXEL_WIDTH]. Pixel 0 is the leftmost.
- Beat addresses are raster order starting at 0. beats_per_line = cfg_width/PPB.
- start is rejected, with a cfg_err pulse and no other effect, if any of these hold: width==0, height==0, width>MAX_W, height>MAX_H, width%PPB!=0.
- start while busy is ignored. No cfg_err is raised.
- FSM states:
  - IDLE -> LINE on a valid start.
  - LINE: issues reads. On the line's last read: -> GAP if cfg_line_gap!=0, else straight into the next line.
  - GAP: counts cfg_line_gap cycles, then -> LINE.
  - After the last read of the last line -> DRAIN.
  - DRAIN: waits for the buffer to empty.
  - At frame_done: -> LINE with rd_addr=0 if cfg_continuous=1, else -> IDLE.
  - The blanking gap is not applied after a frame's last line.
- Read flow control: a 2-entry output buffer with credit counting. rd_en is asserted only when entries + in_flight - pop < 2, where pop = tvalid&tready in the same cycle. This guarantees no overflow and one beat per cycle under tready=1.
- tuser and tlast are computed at read-issue time and carried through the buffer alongside the data.
- Data never drops or duplicates under any tready pattern.

## Timing
- Reset values: all outputs 0; rd_addr=0; FSM in IDLE; buffer empty; credits cleared.
- Reset is honoured mid-frame: tvalid=0 the cycle after reset is asserted, and the partial frame is discarded.
- Latency for start accepted at cycle 0:
  - first rd_en at cycle 1;
  - rd_data at cycle 2;
  - tvalid=1 at cycle 3.
- Throughput: 1 beat per cycle with continuous tready.
- AXI-Stream rules: once tvalid is raised, tvalid, tdata, tlast and tuser hold stable until tready. tvalid never depends combinationally on tready.
- frame_done is asserted the cycle after the accepting handshake of the last beat. busy falls in the same cycle in single-shot mode.
- In continuous mode, the next frame's first rd_en may be issued in the cycle after frame_done.
- cfg_width and cfg_height changes while busy have no effect until the next accepted start.

## Structure
- img_processing_pkg:
  - add typedef streamer_state_t {IDLE, LINE, GAP, DRAIN};
  - add localparam defaults derived from IMG_W, IMG_H and AXIS_TDATA_WIDTH.
- Sub-module axis_out_buf: 2-entry valid/ready buffer carrying {tuser, tlast, tdata}. It exposes an occupancy output for credit counting.
- Top level: FSM, line/beat/gap counters, address generator, credit logic.

## Test plan
- Basic frame: width=4, height=2, PPB=1, gap=0, tready=1, memory word k = k. Required:
  - beats 0..7 in order;
  - tuser only on beat 0;
  - tlast on beats 3 and 7;
  - first tvalid 3 cycles after start;
  - frame_done one cycle after beat 7.
- Random backpressure: width=8, height=3, PPB=2, tready random at 50%. Required:
  - 12 beats, identical sequence to the tready=1 run;
  - tdata held stable while stalled;
  - tready=0 for 20 cycles produces no rd_en beyond 2 outstanding.
- Line gap: gap=5. Required:
  - exactly 5 cycles with rd_en=0 between a line's last read and the next line's first read;
  - no gap after the last line.
- Continuous mode: cfg_continuous=1 for 3 frames, then cleared. Required:
  - 3 frame_done pulses;
  - tuser on the first beat of every frame;
  - busy falls after the 3rd frame.
- Invalid config: width=6 with PPB=4, then height=0. Required: cfg_err pulse each time, busy stays 0, no rd_en.
- Mid-frame reset: reset asserted at beat 5 of a 4x4 frame. Required:
  - tvalid=0 the next cycle;
  - a fresh start replays from address 0 with tuser on the first beat.
